flow_quant_sched: RTL and testbench

//  Sequences the quantization divider. It sits directly upstream of the flow divider and tracks

---
 rtl/flow_quant_sched_if.sv | 29 ++
 rtl/flow_quant_sched.sv | 136 +++++++++++++
 tb/tb_flow_quant_sched.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_quant_sched_if.sv
// Stream bundle between the upstream coefficient source, the quantization sequencer
// and the flow divider.
interface flow_quant_sched_if #(
    parameter int N = 2
);
    logic            in_valid;
    logic [N*16-1:0] in_data;
    logic            in_sob;
    logic            in_eob;
    logic            in_sof;

    logic            out_valid;
    logic [N*16-1:0] out_data;
    logic [N*10-1:0] out_denom;
    logic            out_sob;
    logic            out_eob;
    logic            out_sof;
    logic            out_tbl;

    modport master (
        output in_valid, in_data, in_sob, in_eob, in_sof,
        input  out_valid, out_data, out_denom, out_sob, out_eob, out_sof, out_tbl
    );

    modport slave (
        input  in_valid, in_data, in_sob, in_eob, in_sof,
        output out_valid, out_data, out_denom, out_sob, out_eob, out_sof, out_tbl
    );
endinterface

// File: rtl/flow_quant_sched.sv
// Quantization-divider sequencer: tracks beat/block position, fetches denominators, flags protocol errors.
// Build option FLOW_QSCHED_ZIGZAG_EN: stream arrives in zigzag order and lookups go through a zigzag ROM.
//   state | meaning
//   IDLE  | between blocks, the next valid beat must carry sob
//   BLK   | inside a block, beat_q is the position of the next beat
module flow_quant_sched #(
    parameter int N           = 2,
    parameter int COMPS       = 6,
    parameter int LUMA_BLOCKS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    flow_quant_sched_if.slave s,
    input  logic              cfg_we_i,
    input  logic              cfg_tbl_i,
    input  logic [5:0]        cfg_addr_i,
    input  logic [9:0]        cfg_wdata_i,
    input  logic              err_clr_i,
    output logic              err_o
);
    localparam int BEATS = 64 / N;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = (COMPS > 1) ? $clog2(COMPS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] LAST_COMP = CW'(COMPS - 1);

    typedef enum logic {IDLE, BLK} state_t;

    state_t          state_q;
    logic [BW-1:0]   beat_q;
    logic [BW-1:0]   beat_eff;
    logic [CW-1:0]   comp_q;
    logic [CW-1:0]   comp_blk;
    logic [CW-1:0]   comp_d;
    logic            tbl_q;
    logic            tbl_d;
    logic            err_q;
    logic            is_blk;
    logic            at_last;
    logic            emit;
    logic            blk_end;
    logic            err_ev;
    logic [N*10-1:0] denom_d;
    logic [9:0]      tbl_mem [2][64];

`ifdef FLOW_QSCHED_ZIGZAG_EN
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10, 6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46, 6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
    function automatic logic [5:0] addr_of(input logic [5:0] k);
        return ZZ[k];
    endfunction
`else
    function automatic logic [5:0] addr_of(input logic [5:0] k);
        return k;
    endfunction
`endif

    function automatic logic [CW-1:0] comp_inc(input logic [CW-1:0] c);
        return (c == LAST_COMP) ? '0 : c + 1'b1;
    endfunction

    // A sob inside a block closes the aborted block first, so its comp advance lands before the new block.
    always_comb begin
        is_blk   = (state_q == BLK);
        beat_eff = s.in_sob ? '0 : beat_q;
        comp_blk = comp_q;
        if (s.in_sob) begin
            if (s.in_sof)    comp_blk = '0;
            else if (is_blk) comp_blk = comp_inc(comp_q);
        end
        at_last = (beat_eff == LAST_BEAT);
        emit    = s.in_valid & (is_blk | s.in_sob);
        blk_end = emit & (s.in_eob | at_last);
        err_ev  = s.in_valid & ((!is_blk & !s.in_sob) | (is_blk & s.in_sob)
                                | (blk_end & !(s.in_eob & at_last)));
        comp_d  = blk_end ? comp_inc(comp_blk) : (emit ? comp_blk : comp_q);
        tbl_d   = s.in_sob ? (int'(comp_blk) >= LUMA_BLOCKS) : tbl_q;
        denom_d = '0;
        for (int i = 0; i < N; i++)
            denom_d[i*10 +: 10] = tbl_mem[tbl_d][addr_of(6'(int'(beat_eff) * N + i))];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            comp_q      <= '0;
            tbl_q       <= 1'b0;
            err_q       <= 1'b0;
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_denom <= '0;
            s.out_sob   <= 1'b0;
            s.out_eob   <= 1'b0;
            s.out_sof   <= 1'b0;
            s.out_tbl   <= 1'b0;
        end else if (en_i) begin
            s.out_valid <= emit;
            if (emit) begin
                s.out_data  <= s.in_data;
                s.out_denom <= denom_d;
                s.out_sob   <= s.in_sob;
                s.out_eob   <= s.in_eob | at_last;
                s.out_sof   <= s.in_sob & s.in_sof;
                s.out_tbl   <= tbl_d;
                state_q     <= blk_end ? IDLE : BLK;
                beat_q      <= blk_end ? '0 : beat_eff + 1'b1;
                tbl_q       <= tbl_d;
                comp_q      <= comp_d;
            end else begin
                s.out_sob <= 1'b0;
                s.out_eob <= 1'b0;
                s.out_sof <= 1'b0;
            end
            err_q <= err_ev | (err_q & !err_clr_i);
        end
    end

    // Table writes bypass en; a same-cycle lookup of the written entry still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < 2; t++)
                for (int k = 0; k < 64; k++)
                    tbl_mem[t][k] <= 10'd1;
        end else if (cfg_we_i) begin
            tbl_mem[cfg_tbl_i][cfg_addr_i] <= (cfg_wdata_i == 10'd0) ? 10'd1 : cfg_wdata_i;
        end
    end

    assign err_o = err_q;
endmodule

// File: tb/tb_flow_quant_sched.sv
// Self-checking bench for flow_quant_sched: block-level reference model plus directed scenarios
// and a randomized stream phase.
module tb_flow_quant_sched;
    localparam int N     = 2;
    localparam int BEATS = 64 / N;
    localparam int COMPS = 6;
    localparam int LUMA  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cfg_we;
    logic       cfg_tbl;
    logic [5:0] cfg_addr;
    logic [9:0] cfg_wdata;
    logic       err_clr;
    logic       err;

    flow_quant_sched_if #(.N(N)) bus ();

    flow_quant_sched #(.N(N), .COMPS(COMPS), .LUMA_BLOCKS(LUMA)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .s          (bus),
        .cfg_we_i   (cfg_we),
        .cfg_tbl_i  (cfg_tbl),
        .cfg_addr_i (cfg_addr),
        .cfg_wdata_i(cfg_wdata),
        .err_clr_i  (err_clr),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: block bookkeeping in terms of "open block", position and block index.
    int zz[64] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
                   12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
                   35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                   58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
    int tbl_m[2][64];
    bit live = 0;
    bit m_open;
    int m_pos, m_blk, m_tbl;
    logic            e_valid, e_sob, e_eob, e_sof, e_tbl, e_err;
    logic [N*16-1:0] e_data;
    logic [N*10-1:0] e_denom;

    function automatic int addr_of(input int k);
`ifdef FLOW_QSCHED_ZIGZAG_EN
        return zz[k];
`else
        return k;
`endif
    endfunction

    task automatic mdl_step();
        bit ev, go, last;
        if (rst) begin
            live = 1; m_open = 0; m_pos = 0; m_blk = 0; m_tbl = 0;
            e_valid = 0; e_sob = 0; e_eob = 0; e_sof = 0; e_tbl = 0; e_err = 0;
            e_data = '0; e_denom = '0;
            for (int t = 0; t < 2; t++) for (int k = 0; k < 64; k++) tbl_m[t][k] = 1;
            return;
        end
        if (en) begin
            ev = 0;
            go = 0;
            if (bus.in_valid) begin
                go = 1;
                if (bus.in_sob) begin
                    if (m_open) begin
                        ev = 1;
                        m_blk = (m_blk + 1) % COMPS;
                    end
                    if (bus.in_sof) m_blk = 0;
                    m_tbl = (m_blk >= LUMA) ? 1 : 0;
                    m_pos = 0;
                    m_open = 1;
                end else if (!m_open) begin
                    go = 0;
                    ev = 1;
                end
            end
            e_valid = go;
            if (go) begin
                last    = (m_pos == BEATS - 1);
                e_data  = bus.in_data;
                for (int i = 0; i < N; i++)
                    e_denom[i*10 +: 10] = 10'(tbl_m[m_tbl][addr_of(m_pos * N + i)]);
                e_sob = bus.in_sob;
                e_sof = bus.in_sob & bus.in_sof;
                e_eob = bus.in_eob | last;
                e_tbl = 1'(m_tbl);
                if (bus.in_eob || last) begin
                    if (!(bus.in_eob && last)) ev = 1;
                    m_blk = (m_blk + 1) % COMPS;
                    m_open = 0;
                end else begin
                    m_pos++;
                end
            end
            e_err = ev ? 1'b1 : (err_clr ? 1'b0 : e_err);
        end
        if (cfg_we) tbl_m[cfg_tbl][cfg_addr] = (cfg_wdata == 0) ? 1 : int'(cfg_wdata);
    endtask

    always @(posedge clk) mdl_step();

    always @(negedge clk) begin
        if (live) begin
            chk("out_valid", 64'(bus.out_valid), 64'(e_valid));
            chk("err", 64'(err), 64'(e_err));
            if (e_valid) begin
                chk("out_data", 64'(bus.out_data), 64'(e_data));
                chk("out_denom", 64'(bus.out_denom), 64'(e_denom));
                chk("out_sob", 64'(bus.out_sob), 64'(e_sob));
                chk("out_eob", 64'(bus.out_eob), 64'(e_eob));
                chk("out_sof", 64'(bus.out_sof), 64'(e_sof));
                chk("out_tbl", 64'(bus.out_tbl), 64'(e_tbl));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_sob = 0; bus.in_eob = 0; bus.in_sof = 0;
        tick();
    endtask

    task automatic send_beat(input bit sob, input bit eob, input bit sof);
        bus.in_valid = 1;
        for (int i = 0; i < N; i++) bus.in_data[i*16 +: 16] = 16'($urandom);
        bus.in_sob = sob; bus.in_eob = eob; bus.in_sof = sof;
        tick();
    endtask

    task automatic send_block(input bit sof, input int nbeats, input int eob_at);
        for (int b = 0; b < nbeats; b++) send_beat(b == 0, b == eob_at, sof && b == 0);
        idle();
    endtask

    task automatic cfg_write(input bit t, input int a, input int d);
        cfg_we = 1; cfg_tbl = t; cfg_addr = 6'(a); cfg_wdata = 10'(d);
        tick();
        cfg_we = 0;
    endtask

    task automatic clear_err();
        err_clr = 1;
        idle();
        err_clr = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*16-1:0] held;
        rst = 1; en = 1; cfg_we = 0; cfg_tbl = 0; cfg_addr = 0; cfg_wdata = 0; err_clr = 0;
        bus.in_valid = 0; bus.in_data = '0; bus.in_sob = 0; bus.in_eob = 0; bus.in_sof = 0;
        tick(); tick();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_denom", 64'(bus.out_denom), 64'd0);
        chk("rst_flags", 64'({bus.out_sob, bus.out_eob, bus.out_sof, bus.out_tbl}), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 0;

        // clean block on reset tables
        idle();
        chk("t1_idle_valid", 64'(bus.out_valid), 64'd0);
        for (int b = 0; b < BEATS; b++) begin
            send_beat(b == 0, b == BEATS - 1, 0);
            chk("t1_valid", 64'(bus.out_valid), 64'd1);
            chk("t1_denom", 64'(bus.out_denom), 64'({10'd1, 10'd1}));
        end
        chk("t1_eob", 64'(bus.out_eob), 64'd1);
        idle();
        chk("t1_err", 64'(err), 64'd0);

        // programmed tables over a full MCU
        for (int k = 0; k < 64; k++) begin
            cfg_write(0, k, k + 1);
            cfg_write(1, k, 2 * k + 3);
        end
        for (int blk = 0; blk < COMPS; blk++) begin
            for (int b = 0; b < BEATS; b++) begin
                send_beat(b == 0, b == BEATS - 1, blk == 0 && b == 0);
                if (b == 5) begin
                    chk("t2_tbl", 64'(bus.out_tbl), (blk < LUMA) ? 64'd0 : 64'd1);
`ifndef FLOW_QSCHED_ZIGZAG_EN
                    chk("t2_denom_l1", 64'(bus.out_denom[19:10]), (blk < LUMA) ? 64'd12 : 64'd25);
`endif
                end
            end
        end
        idle();

        // early eob, stray beat, error clear
        send_block(0, 11, 10);
        chk("t3_err", 64'(err), 64'd1);
        send_beat(0, 0, 0);
        chk("t3_stray_drop", 64'(bus.out_valid), 64'd0);
        clear_err();
        chk("t3_err_clr", 64'(err), 64'd0);
        send_block(0, BEATS, BEATS - 1);
        chk("t3_err_stays", 64'(err), 64'd0);

        // restart with sof mid-block
        send_block(0, BEATS, BEATS - 1);
        send_block(0, BEATS, BEATS - 1);
        for (int b = 0; b < 20; b++) begin
            send_beat(b == 0, 0, 0);
            if (b == 0) chk("t4_chroma_tbl", 64'(bus.out_tbl), 64'd1);
        end
        send_beat(1, 0, 1);
        chk("t4_sob", 64'(bus.out_sob), 64'd1);
        chk("t4_tbl", 64'(bus.out_tbl), 64'd0);
        chk("t4_err", 64'(err), 64'd1);
        for (int b = 1; b < BEATS; b++) send_beat(0, b == BEATS - 1, 0);
        clear_err();

        // clock-enable freeze with a config write underneath
        send_beat(1, 0, 1);
        held = bus.out_data;
        en = 0;
        for (int c = 0; c < 3; c++) begin
            bus.in_data = ~bus.in_data;
            if (c == 0) cfg_write(0, 3, 0);
            else tick();
            chk("t5_frozen_data", 64'(bus.out_data), 64'(held));
            chk("t5_frozen_sob", 64'(bus.out_sob), 64'd1);
        end
        en = 1;
        for (int b = 1; b < BEATS; b++) begin
            send_beat(0, b == BEATS - 1, 0);
`ifndef FLOW_QSCHED_ZIGZAG_EN
            if (b == 1) chk("t5_denom_c3", 64'(bus.out_denom[19:10]), 64'd1);
`endif
        end
        idle();

`ifdef FLOW_QSCHED_ZIGZAG_EN
        for (int k = 0; k < 64; k++) cfg_write(0, k, k);
        for (int b = 0; b < BEATS; b++) begin
            send_beat(b == 0, b == BEATS - 1, b == 0);
            if (b == 1) chk("t6_beat1", 64'(bus.out_denom), 64'({10'd16, 10'd8}));
            if (b == 2) chk("t6_beat2", 64'(bus.out_denom), 64'({10'd2, 10'd9}));
        end
        idle();
`endif

        // randomized stream
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom % 400) == 0;
            en       = ($urandom % 8) != 0;
            err_clr  = ($urandom % 16) == 0;
            cfg_we   = ($urandom % 6) == 0;
            cfg_tbl  = 1'($urandom);
            cfg_addr = 6'($urandom);
            cfg_wdata = (($urandom % 8) == 0) ? 10'd0 : 10'($urandom);
            bus.in_valid = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) bus.in_data[i*16 +: 16] = 16'($urandom);
            bus.in_sob = m_open ? (($urandom % 60) == 0) : (($urandom % 5) != 0);
            bus.in_eob = (m_open && m_pos == BEATS - 1) ? (($urandom % 5) != 0) : (($urandom % 50) == 0);
            bus.in_sof = ($urandom % 4) == 0;
            tick();
        end
        rst = 0; en = 1; cfg_we = 0; err_clr = 0;
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
